uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 128 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a byte FIFO, with per-frame latched format and baud divisor.
module uart_tx_fifo #(
  parameter int DIV_WID    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [DIV_WID-1:0] baud_div,
  input  logic               tx_en,
  input  logic [1:0]         cfg_dbits,
  input  logic               cfg_par_en,
  input  logic               cfg_par_odd,
  input  logic               cfg_stop2,
  input  logic               wr_valid,
  input  logic [7:0]         wr_data,
  output logic               wr_ready,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               fifo_full,
  output logic               fifo_empty,
  output logic               busy,
  output logic               tx_done,
  output logic               uart_txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               state_q;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q;
  logic [DIV_WID-1:0]   cnt_q, div_q;
  logic [2:0]           bit_q;
  logic [1:0]           dbits_q;
  logic [7:0]           sh_q, head, mask;
  logic                 par_q, par_en_q, stop2_q, stop_q, txd_q;
  logic                 push, pop, tick, last_stop;

  assign head       = mem_q[rd_ptr_q];
  assign mask       = 8'hff >> (2'd3 - cfg_dbits);
  assign fifo_level = level_q;
  assign fifo_full  = level_q == LVL_W'(FIFO_DEPTH);
  assign fifo_empty = level_q == '0;
  assign wr_ready   = !fifo_full;
  assign push       = wr_valid && wr_ready;
  assign tick       = cnt_q == '0;
  assign last_stop  = !stop2_q || stop_q;
  assign tx_done    = state_q == STOP && tick && last_stop;
  // Empty is judged on the registered level, so a byte pushed into an empty FIFO pops a cycle later.
  assign pop        = tx_en && !fifo_empty && (state_q == IDLE || tx_done);
  assign busy       = state_q != IDLE;
  assign uart_txd   = txd_q;

  always_ff @(posedge hclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      level_q  <= level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      dbits_q  <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      stop_q   <= 1'b0;
      txd_q    <= 1'b1;
    end else if (pop) begin
      state_q  <= START;
      txd_q    <= 1'b0;
      cnt_q    <= baud_div;
      div_q    <= baud_div;
      dbits_q  <= cfg_dbits;
      sh_q     <= head;
      par_q    <= ^(head & mask) ^ cfg_par_odd;
      par_en_q <= cfg_par_en;
      stop2_q  <= cfg_stop2;
      stop_q   <= 1'b0;
      bit_q    <= '0;
    end else if (state_q != IDLE) begin
      if (!tick) begin
        cnt_q <= cnt_q - DIV_WID'(1);
      end else begin
        cnt_q <= div_q;
        case (state_q)
          START: begin
            state_q <= DATA;
            txd_q   <= sh_q[0];
            sh_q    <= sh_q >> 1;
          end
          DATA: begin
            if (bit_q == 3'(dbits_q) + 3'd4) begin
              state_q <= par_en_q ? PARITY : STOP;
              txd_q   <= par_en_q ? par_q : 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              txd_q <= sh_q[0];
              sh_q  <= sh_q >> 1;
            end
          end
          PARITY: begin
            state_q <= STOP;
            txd_q   <= 1'b1;
          end
          STOP: begin
            if (last_stop) state_q <= IDLE;
            else stop_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed frame, FIFO and reset checks for uart_tx_fifo.
module tb_uart_tx_fifo;
  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic [15:0] baud_div = '0;
  logic        tx_en = 1'b0;
  logic [1:0]  cfg_dbits = 2'd3;
  logic        cfg_par_en = 1'b0;
  logic        cfg_par_odd = 1'b0;
  logic        cfg_stop2 = 1'b0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready, fifo_full, fifo_empty, busy, tx_done, uart_txd;
  logic [3:0]  fifo_level;
  int          total = 0;
  int          bad = 0;

  uart_tx_fifo dut (
    .hclk(hclk), .hresetn(hresetn), .baud_div(baud_div), .tx_en(tx_en),
    .cfg_dbits(cfg_dbits), .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd),
    .cfg_stop2(cfg_stop2), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .fifo_level(fifo_level), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .busy(busy), .tx_done(tx_done), .uart_txd(uart_txd)
  );

  always #5 hclk = ~hclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    @(negedge hclk);
    wr_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] div, input logic [1:0] db, input logic pe,
                         input logic po, input logic s2);
    baud_div    = div;
    cfg_dbits   = db;
    cfg_par_en  = pe;
    cfg_par_odd = po;
    cfg_stop2   = s2;
  endtask

  task automatic wait_start(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (uart_txd !== 1'b0 && n < 50) begin
      @(negedge hclk);
      n++;
    end
    chk(tag, n, exp_lat);
  endtask

  task automatic run_frame(input string tag, input logic [11:0] seq, input int nb, input int per);
    int err;
    for (int i = 0; i < nb; i++) begin
      err = 0;
      for (int k = 0; k < per; k++) begin
        if (uart_txd !== seq[i] || busy !== 1'b1 || tx_done !== (i == nb - 1 && k == per - 1)) err++;
        @(negedge hclk);
      end
      chk($sformatf("%s_bit%0d", tag, i), err, 0);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_txd"}, 32'(uart_txd), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
  endtask

  initial begin
    int err;
    logic [7:0] d;
    repeat (2) @(negedge hclk);
    chk("rst_txd", 32'(uart_txd), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_ready", 32'(wr_ready), 1);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    hresetn = 1'b1;
    tx_en   = 1'b1;
    repeat (5) @(negedge hclk);
    chk("no_start_after_rst", 32'(busy), 0);

    set_cfg(16'd9, 2'd3, 1'b0, 1'b0, 1'b0);
    push(8'hA5);
    wait_start("8n1_latency", 1);
    run_frame("8n1", 12'b00_1101001010, 10, 10);
    idle_chk("8n1_end");

    set_cfg(16'd3, 2'd3, 1'b1, 1'b0, 1'b0);
    push(8'hA5);
    wait_start("8e1_latency", 1);
    run_frame("8e1", 12'b0_10101001010, 11, 4);
    idle_chk("8e1_end");
    cfg_par_odd = 1'b1;
    push(8'hA5);
    wait_start("8o1_latency", 1);
    run_frame("8o1", 12'b0_11101001010, 11, 4);
    idle_chk("8o1_end");

    set_cfg(16'd1, 2'd2, 1'b0, 1'b0, 1'b1);
    push(8'hFF);
    wait_start("7n2_latency", 1);
    run_frame("7n2", 12'b0011_1111_1110, 10, 2);
    idle_chk("7n2_end");

    set_cfg(16'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    push(8'hE0);
    wait_start("5e1_latency", 1);
    run_frame("5e1", 12'b0000_1000_0000, 8, 1);
    idle_chk("5e1_end");

    set_cfg(16'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    tx_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_data  = 8'h10 + 8'(i);
      wr_valid = 1'b1;
      @(negedge hclk);
      if (i == 3) chk("fill_level4", 32'(fifo_level), 4);
    end
    wr_valid = 1'b0;
    chk("full_level", 32'(fifo_level), 8);
    chk("full_flag", 32'(fifo_full), 1);
    chk("full_ready", 32'(wr_ready), 0);
    chk("full_busy", 32'(busy), 0);
    tx_en = 1'b1;
    wait_start("burst_latency", 1);
    for (int k = 0; k < 8; k++) begin
      d = 8'h10 + 8'(k);
      chk($sformatf("burst%0d_level", k), 32'(fifo_level), 32'(7 - k));
      run_frame($sformatf("burst%0d", k), {2'b00, 1'b1, d, 1'b0}, 10, 1);
    end
    idle_chk("burst_end");
    chk("burst_empty", 32'(fifo_empty), 1);

    set_cfg(16'd9, 2'd3, 1'b0, 1'b0, 1'b0);
    tx_en = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    tx_en = 1'b1;
    wait_start("rst_mid_latency", 1);
    chk("rst_mid_level3", 32'(fifo_level), 3);
    repeat (15) @(negedge hclk);
    #2 hresetn = 1'b0;
    #1;
    chk("rst_mid_txd", 32'(uart_txd), 1);
    chk("rst_mid_level", 32'(fifo_level), 0);
    chk("rst_mid_empty", 32'(fifo_empty), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_ready", 32'(wr_ready), 1);
    @(negedge hclk);
    hresetn = 1'b1;
    err = 0;
    for (int i = 0; i < 30; i++) begin
      if (uart_txd !== 1'b1 || busy !== 1'b0) err++;
      @(negedge hclk);
    end
    chk("rst_mid_quiet", err, 0);
    baud_div = 16'd1;
    push(8'hA5);
    wait_start("rst_mid_new_latency", 1);
    run_frame("rst_mid_new", 12'b00_1101001010, 10, 2);
    idle_chk("rst_mid_new_end");

    set_cfg(16'd3, 2'd3, 1'b0, 1'b0, 1'b0);
    tx_en = 1'b0;
    push(8'hA5);
    push(8'h3C);
    chk("cfg_level2", 32'(fifo_level), 2);
    tx_en = 1'b1;
    wait_start("cfg_latency", 1);
    fork
      run_frame("cfg_old", 12'b00_1101001010, 10, 4);
      begin
        repeat (10) @(negedge hclk);
        cfg_dbits = 2'd0;
        baud_div  = 16'd1;
      end
    join
    run_frame("cfg_new", 12'b0000_0111_1000, 7, 2);
    idle_chk("cfg_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
